// File: rtl/fp_mul_iter_if.sv
// Operand/result handshake bundle for fp_mul_iter: valid/ready in, valid/ready out.
// master = producer/consumer side, slave = the multiplier.
interface fp_mul_iter_if #(
  parameter int NEXP = 5,
  parameter int NSIG = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NEXP+NSIG:0]   a;
  logic [NEXP+NSIG:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [NEXP+NSIG:0]   p;
  logic [3:0]           exc;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, exc
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, exc
  );
endinterface

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 multiplier (shift-and-add, RNE); NSIG+4 edges accept->out_valid, 1 for special operands.
// No in/out overlap, result held while out_ready low; FP_MUL_FTZ_EN selects flush-to-zero.
module fp_class #(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic [NEXP+NSIG:0]     x,
  output logic                   fSign,
  output logic signed [NEXP+2:0] fExp,
  output logic [NSIG:0]          fSig,
  output logic [3:0]             fFlags
);
  localparam int EW   = NEXP + 3;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;

  logic [NEXP-1:0] e;
  logic [NSIG-1:0] f;
  logic            eZero, eOnes, fZero;
  int              lz;

  assign fSign = x[NEXP+NSIG];
  assign e     = x[NEXP+NSIG-1:NSIG];
  assign f     = x[NSIG-1:0];
  assign eZero = (e == '0);
  assign eOnes = (e == '1);
  assign fZero = (f == '0);

  // Subnormals are renormalised so finite nonzero significands always carry the hidden bit.
  always_comb begin
    lz = 0;
    for (int i = 0; i < NSIG; i++)
      if (f[i]) lz = NSIG - 1 - i;
    if (eZero) begin
      fSig = {1'b0, f} << (lz + 1);
      fExp = EW'(-BIAS - lz);
    end else begin
      fSig = {1'b1, f};
      fExp = $signed({3'b000, e}) - EW'(BIAS);
    end
  end

  // {sNaN, qNaN, inf, zero}
  assign fFlags = {eOnes & ~fZero & ~f[NSIG-1], eOnes & f[NSIG-1], eOnes & fZero, eZero & fZero};
endmodule

module fp_mul_iter #(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input logic          clk,
  input logic          reset,
  fp_mul_iter_if.slave bus
);
  localparam int W    = NEXP + NSIG + 1;
  localparam int ACCW = 2 * NSIG + 2;
  localparam int EW   = NEXP + 3;
  localparam int CW   = $clog2(NSIG + 2);
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam int EMAX = BIAS;

  localparam logic signed [EW-1:0] EMIN_E  = EW'(EMIN);
  localparam logic signed [EW-1:0] EXP_TOP = EW'(EMAX + BIAS + 1);
  localparam logic [W-1:0]         QNAN    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MUL, NORM, ROUND, DONE} stateT;
  stateT state, stateNext;

  logic [W-1:0]         aReg, bReg, pReg;
  logic [3:0]           excReg;
  logic                 sign;
  logic signed [EW-1:0] expSum;
  logic [ACCW-1:0]      acc;
  logic [NSIG:0]        bShift;
  logic [CW-1:0]        cnt;
  logic                 sticky;
`ifdef FP_MUL_FTZ_EN
  logic                 ftzFlush;
`endif

  logic                 sA, sB;
  logic signed [EW-1:0] expA, expB;
  logic [NSIG:0]        sigA, sigB;
  logic [3:0]           flA, flB;

  fp_class #(.NEXP(NEXP), .NSIG(NSIG)) classA (.x(aReg), .fSign(sA), .fExp(expA), .fSig(sigA), .fFlags(flA));
  fp_class #(.NEXP(NEXP), .NSIG(NSIG)) classB (.x(bReg), .fSign(sB), .fExp(expB), .fSig(sigB), .fFlags(flB));

  logic           zeroA, zeroB, anySnan, anyQnan, anyInf, anyZero, special;
  logic [W-1:0]   specP;
  logic [3:0]     specExc;

`ifdef FP_MUL_FTZ_EN
  assign zeroA = flA[0] | (aReg[W-2:NSIG] == '0);
  assign zeroB = flB[0] | (bReg[W-2:NSIG] == '0);
`else
  assign zeroA = flA[0];
  assign zeroB = flB[0];
`endif
  assign anySnan = flA[3] | flB[3];
  assign anyQnan = flA[2] | flB[2];
  assign anyInf  = flA[1] | flB[1];
  assign anyZero = zeroA | zeroB;
  assign special = anySnan | anyQnan | anyInf | anyZero;

  always_comb begin
    specP   = {sA ^ sB, {(W-1){1'b0}}};
    specExc = 4'b0000;
    if (anySnan | anyQnan | (anyInf & anyZero)) begin
      specP      = QNAN;
      specExc[3] = anySnan | (anyInf & anyZero);
    end else if (anyInf) begin
      specP = {sA ^ sB, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end
  end

  // One multiplier bit per cycle; the carry of the add lands in the accumulator MSB after the shift.
  logic [NSIG+1:0] addSum;
  assign addSum = {1'b0, acc[ACCW-1:NSIG+1]} + (bShift[0] ? {1'b0, sigA} : '0);

  logic [ACCW-1:0]      prodN, lostMask, prodSub;
  logic signed [EW-1:0] expN, shAmt;
  logic                 tiny, lostBits;

  always_comb begin
    prodN    = acc[ACCW-1] ? acc : {acc[ACCW-2:0], 1'b0};
    expN     = acc[ACCW-1] ? expSum + EW'(1) : expSum;
    tiny     = expN < EMIN_E;
    shAmt    = EMIN_E - expN;
    lostMask = '1;
    prodSub  = '0;
    if (shAmt < EW'(ACCW)) begin
      lostMask = ~({ACCW{1'b1}} << shAmt);
      prodSub  = prodN >> shAmt;
    end
    lostBits = |(prodN & lostMask);
  end

  logic                 g, r, s, inc, inexact, ovf, uf;
  logic signed [EW-1:0] biased;
  logic [W-2:0]         mag, magR;
  logic [W-1:0]         roundP;
  logic [3:0]           roundExc;

  // Rounding increments {field, fraction} as one word so a fraction carry bumps the exponent,
  // including subnormal -> smallest normal and largest finite -> inf.
  always_comb begin
    g        = acc[NSIG];
    r        = acc[NSIG-1];
    s        = sticky | (|acc[NSIG-2:0]);
    inc      = g & (r | s | acc[NSIG+1]);
    inexact  = g | r | s;
    biased   = expSum + EW'(BIAS);
    mag      = {biased[NEXP-1:0], acc[2*NSIG:NSIG+1]};
    magR     = mag + (W-1)'(inc);
    ovf      = (biased >= EXP_TOP) | (&magR[W-2:NSIG]);
    uf       = (magR[W-2:NSIG] == '0) & inexact;
    roundP   = {sign, magR};
    roundExc = {2'b00, uf, inexact};
    if (ovf) begin
      roundP   = {sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
      roundExc = 4'b0101;
    end
`ifdef FP_MUL_FTZ_EN
    if (ftzFlush) begin
      roundP   = {sign, {(W-1){1'b0}}};
      roundExc = 4'b0011;
    end
`endif
  end

  logic inReadyC, outValidC;

  always_comb begin
    stateNext = state;
    inReadyC  = 1'b0;
    outValidC = 1'b0;
    case (state)
      IDLE: begin
        inReadyC = 1'b1;
        if (bus.in_valid) stateNext = LOAD;
      end
      LOAD:    stateNext = special ? DONE : MUL;
      MUL:     if (cnt == CW'(NSIG)) stateNext = NORM;
      NORM:    stateNext = ROUND;
      ROUND:   stateNext = DONE;
      DONE: begin
        outValidC = 1'b1;
        if (bus.out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aReg     <= '0;
      bReg     <= '0;
      pReg     <= '0;
      excReg   <= '0;
      sign     <= 1'b0;
      expSum   <= '0;
      acc      <= '0;
      bShift   <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
`ifdef FP_MUL_FTZ_EN
      ftzFlush <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          aReg <= bus.a;
          bReg <= bus.b;
        end
        LOAD: begin
          sign     <= sA ^ sB;
          expSum   <= expA + expB;
          acc      <= '0;
          cnt      <= '0;
          bShift   <= sigB;
          sticky   <= 1'b0;
`ifdef FP_MUL_FTZ_EN
          ftzFlush <= 1'b0;
`endif
          if (special) begin
            pReg   <= specP;
            excReg <= specExc;
          end
        end
        MUL: begin
          acc    <= {addSum, acc[NSIG:1]};
          bShift <= bShift >> 1;
          cnt    <= cnt + CW'(1);
        end
        NORM: begin
          acc      <= tiny ? prodSub : prodN;
          expSum   <= tiny ? EMIN_E - EW'(1) : expN;
          sticky   <= tiny & lostBits;
`ifdef FP_MUL_FTZ_EN
          ftzFlush <= tiny;
`endif
        end
        ROUND: begin
          pReg   <= roundP;
          excReg <= roundExc;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = inReadyC;
  assign bus.out_valid = outValidC;
  assign bus.p         = pReg;
  assign bus.exc       = excReg;
endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed-vector bench for fp_mul_iter at half precision (NEXP=5, NSIG=10).
module tb_fp_mul_iter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nVec  = 0;
  int   nBad  = 0;

  fp_mul_iter_if #(.NEXP(5), .NSIG(10)) bus ();
  fp_mul_iter #(.NEXP(5), .NSIG(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, output int lat);
    @(negedge clk);
    bus.a        = ta;
    bus.b        = tb;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    lat   = 0;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    nVec++;
    if (bus.in_ready !== 1'b1) begin nBad++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    nVec++;
    if (bus.out_valid !== 1'b0) begin nBad++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    nVec++;
    if ({bus.p, bus.exc} !== 20'h0) begin nBad++; $display("FAIL rst_p_exc: got %h/%h expected 0000/0", bus.p, bus.exc); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    nVec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      nBad++; $display("FAIL post_rst_hs: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_normal();
    logic [15:0] va [6] = '{16'h3C00, 16'h3C01, 16'h3E00, 16'hBC00, 16'h4000, 16'h7BFF};
    logic [15:0] vb [6] = '{16'h3C00, 16'h3C01, 16'h3E00, 16'h4000, 16'h4000, 16'h4000};
    logic [15:0] ep [6] = '{16'h3C00, 16'h3C02, 16'h4080, 16'hC000, 16'h4400, 16'h7C00};
    logic [3:0]  ee [6] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h5};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], lat);
      nVec++;
      if (bus.p !== ep[i]) begin nBad++; $display("FAIL normal_p[%0d]: got %h expected %h", i, bus.p, ep[i]); end
      nVec++;
      if (bus.exc !== ee[i]) begin nBad++; $display("FAIL normal_exc[%0d]: got %h expected %h", i, bus.exc, ee[i]); end
      nVec++;
      if (lat !== 14) begin nBad++; $display("FAIL normal_lat[%0d]: got %0d expected 14", i, lat); end
      finish_op();
    end
  endtask

  task automatic test_special();
    logic [15:0] va [5] = '{16'h7C00, 16'h7D00, 16'h8000, 16'h7E00, 16'hFC00};
    logic [15:0] vb [5] = '{16'h0000, 16'h3C00, 16'h3C00, 16'h7C00, 16'h4000};
    logic [15:0] ep [5] = '{16'h7E00, 16'h7E00, 16'h8000, 16'h7E00, 16'hFC00};
    logic [3:0]  ee [5] = '{4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], lat);
      nVec++;
      if (bus.p !== ep[i]) begin nBad++; $display("FAIL special_p[%0d]: got %h expected %h", i, bus.p, ep[i]); end
      nVec++;
      if (bus.exc !== ee[i]) begin nBad++; $display("FAIL special_exc[%0d]: got %h expected %h", i, bus.exc, ee[i]); end
      nVec++;
      if (lat !== 1) begin nBad++; $display("FAIL special_lat[%0d]: got %0d expected 1", i, lat); end
      finish_op();
    end
  endtask

  task automatic test_subnormal();
    logic [15:0] va [3] = '{16'h0001, 16'h0200, 16'h0400};
    logic [15:0] vb [3] = '{16'h3800, 16'h4000, 16'h3800};
`ifdef FP_MUL_FTZ_EN
    logic [15:0] ep [3] = '{16'h0000, 16'h0000, 16'h0000};
    logic [3:0]  ee [3] = '{4'h0, 4'h0, 4'h3};
    int          el [3] = '{1, 1, 14};
`else
    logic [15:0] ep [3] = '{16'h0000, 16'h0400, 16'h0200};
    logic [3:0]  ee [3] = '{4'h3, 4'h0, 4'h0};
    int          el [3] = '{14, 14, 14};
`endif
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i], lat);
      nVec++;
      if (bus.p !== ep[i]) begin nBad++; $display("FAIL subn_p[%0d]: got %h expected %h", i, bus.p, ep[i]); end
      nVec++;
      if (bus.exc !== ee[i]) begin nBad++; $display("FAIL subn_exc[%0d]: got %h expected %h", i, bus.exc, ee[i]); end
      nVec++;
      if (lat !== el[i]) begin nBad++; $display("FAIL subn_lat[%0d]: got %0d expected %0d", i, lat, el[i]); end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic sawValid;
    start_op(16'h3C00, 16'h4000, lat);
    nVec++;
    if ({bus.p, bus.exc} !== {16'h4000, 4'h0}) begin
      nBad++; $display("FAIL bp_result: got %h/%h expected 4000/0", bus.p, bus.exc);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      nVec++;
      if ({bus.out_valid, bus.in_ready, bus.p, bus.exc} !== {1'b1, 1'b0, 16'h4000, 4'h0}) begin
        nBad++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%b p=%h exc=%h expected v=1 r=0 p=4000 exc=0",
                 i, bus.out_valid, bus.in_ready, bus.p, bus.exc);
      end
      if (i == 1) begin
        bus.a = 16'h4400; bus.b = 16'h4400; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    finish_op();
    nVec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      nBad++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (bus.out_valid === 1'b1) sawValid = 1'b1;
    end
    nVec++;
    if (sawValid !== 1'b0) begin nBad++; $display("FAIL bp_ghost: got out_valid=1 while idle expected 0"); end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(16'h4200, 16'h4200, lat);
    nVec++;
    if ({bus.p, bus.exc} !== {16'h4880, 4'h0}) begin
      nBad++; $display("FAIL b2b_first: got %h/%h expected 4880/0", bus.p, bus.exc);
    end
    finish_op();
    start_op(16'hC400, 16'h3800, lat);
    nVec++;
    if ({bus.p, bus.exc} !== {16'hC000, 4'h0}) begin
      nBad++; $display("FAIL b2b_second: got %h/%h expected c000/0", bus.p, bus.exc);
    end
    nVec++;
    if (lat !== 14) begin nBad++; $display("FAIL b2b_lat: got %0d expected 14", lat); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus.a = 16'h4400; bus.b = 16'h4400; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    nVec++;
    if (bus.in_ready !== 1'b0) begin nBad++; $display("FAIL mid_busy: got in_ready=%b expected 0", bus.in_ready); end
    reset = 1'b1;
    #1;
    nVec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      nBad++; $display("FAIL mid_abort: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    start_op(16'h4000, 16'h4000, lat);
    nVec++;
    if ({bus.p, bus.exc} !== {16'h4400, 4'h0}) begin
      nBad++; $display("FAIL mid_fresh: got %h/%h expected 4400/0", bus.p, bus.exc);
    end
    nVec++;
    if (lat !== 14) begin nBad++; $display("FAIL mid_lat: got %0d expected 14", lat); end
    finish_op();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    test_reset();
    test_normal();
    test_special();
    test_subnormal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
